state_sequencer: RTL and testbench

//  Drives the one-hot state[3:0] vector {exec3,exec2,exec1,fetch} that the instruction decoder consumes.

---
 rtl/state_sequencer_pkg.sv | 42 ++++
 rtl/state_sequencer_inst_class.sv | 18 +
 rtl/state_sequencer.sv | 111 +++++++++++
 tb/tb_state_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/state_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, the one-hot
// state encoding seen by the decoder, and the internal FSM states.
package state_sequencer_pkg;

  // Opcodes the sequencer treats specially; every other code is a short instruction
  localparam logic [3:0] OP_JMP = 4'b0001;
  localparam logic [3:0] OP_STP = 4'b0010;
  localparam logic [3:0] OP_LDA = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_LDR = 4'b1110;

  // One-hot state vector {exec3,exec2,exec1,fetch} consumed by the decoder
  localparam logic [3:0] ST_NONE  = 4'b0000;
  localparam logic [3:0] ST_FETCH = 4'b0001;
  localparam logic [3:0] ST_EXEC1 = 4'b0010;
  localparam logic [3:0] ST_EXEC2 = 4'b0100;
  localparam logic [3:0] ST_EXEC3 = 4'b1000;

  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_FETCH,
    SQ_EXEC1,
    SQ_EXEC2,
    SQ_EXEC3,
    SQ_HALT
  } seq_state_t;

  // IDLE and HALT present an all-zero vector to the decoder
  function automatic logic [3:0] state_onehot(input seq_state_t s);
    logic [3:0] v;
    v = ST_NONE;
    case (s)
      SQ_FETCH: v = ST_FETCH;
      SQ_EXEC1: v = ST_EXEC1;
      SQ_EXEC2: v = ST_EXEC2;
      SQ_EXEC3: v = ST_EXEC3;
      default:  v = ST_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/state_sequencer_inst_class.sv
// Opcode classifier: decides how many execute phases an instruction needs.
module inst_class
  import state_sequencer_pkg::*;
(
  input  logic [3:0] inst,
  output logic       is_stop,
  output logic       is_long_mem,
  output logic       is_long_mul
);

  // Pure decode; undefined opcodes fall through to the short class
  always_comb begin
    is_stop     = (inst == OP_STP);
    is_long_mem = (inst == OP_LDA) || (inst == OP_LDR);
    is_long_mul = (inst == OP_MUL);
  end

endmodule

// File: rtl/state_sequencer.sv
// Instruction sequencer: steps each instruction through FETCH/EXEC1..EXEC3,
// waits on data memory, halts on STP or memory timeout, counts retirements.
module state_sequencer
  import state_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  input  logic             step,
  input  logic [3:0]       inst,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  seq_state_t       fsm_q, fsm_d;
  logic [7:0]       wait_q, wait_d;
  logic             fault_q;
  logic [CNT_W-1:0] retired_q;
  logic             complete;
  logic             timeout;
  logic             is_stop, is_long_mem, is_long_mul;
  seq_state_t       boundary_next;

  inst_class u_inst_class (
    .inst        (inst),
    .is_stop     (is_stop),
    .is_long_mem (is_long_mem),
    .is_long_mul (is_long_mul)
  );

  // Next-state logic; run/step_mode only matter in IDLE and on completing edges
  always_comb begin
    fsm_d         = fsm_q;
    wait_d        = wait_q;
    complete      = 1'b0;
    timeout       = 1'b0;
    boundary_next = (!step_mode && run) ? SQ_FETCH : SQ_IDLE;
    case (fsm_q)
      SQ_IDLE: begin
        if ((!step_mode && run) || (step_mode && step)) fsm_d = SQ_FETCH;
      end
      SQ_FETCH: fsm_d = SQ_EXEC1;
      SQ_EXEC1: begin
        if (is_stop) begin
          fsm_d = SQ_HALT;
        end else if (is_long_mem || is_long_mul) begin
          fsm_d  = SQ_EXEC2;
          wait_d = '0;
        end else begin
          complete = 1'b1;
          fsm_d    = boundary_next;
        end
      end
      SQ_EXEC2: begin
        // mem_ready takes priority over a timeout detected on the same edge
        if (is_long_mul) begin
          fsm_d = SQ_EXEC3;
        end else if (mem_ready) begin
          complete = 1'b1;
          fsm_d    = boundary_next;
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
          fsm_d   = SQ_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      SQ_EXEC3: begin
        complete = 1'b1;
        fsm_d    = boundary_next;
      end
      SQ_HALT: fsm_d = SQ_HALT;
      default: fsm_d = SQ_IDLE;
    endcase
  end

  // State, wait counter, sticky fault flag and retirement counter
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= SQ_IDLE;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      wait_q <= wait_d;
      if (timeout)  fault_q   <= 1'b1;
      if (complete) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs decode only registered state
  always_comb begin
    state   = state_onehot(fsm_q);
    busy    = |state;
    halted  = (fsm_q == SQ_HALT);
    fault   = fault_q;
    retired = retired_q;
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer with a per-cycle expectation queue.
module tb_state_sequencer;
  import state_sequencer_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, run, step_mode, step, mem_ready;
  logic [3:0]    inst;
  logic [3:0]    state;
  logic          busy, halted, fault;
  logic [CW-1:0] retired;

  typedef struct {
    string         tag;
    logic [3:0]    st;
    logic          b;
    logic          h;
    logic          f;
    logic [CW-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  state_sequencer #(.WAIT_MAX(15), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_mode (step_mode),
    .step      (step),
    .inst      (inst),
    .mem_ready (mem_ready),
    .state     (state),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Queue the expectation for the next edge, advance one clock, then compare
  task automatic cyc(input string tag, input logic [3:0] st, input logic b,
                     input logic h, input logic f, input int r);
    exp_t e;
    logic [CW+6:0] obs, want;
    e.tag = tag; e.st = st; e.b = b; e.h = h; e.f = f; e.r = CW'(r);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e    = sb.pop_front();
    obs  = {state, busy, halted, fault, retired};
    want = {e.st, e.b, e.h, e.f, e.r};
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got {state,busy,halted,fault,retired}=%h expected %h", e.tag, obs, want);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
    inst = OP_JMP; mem_ready = 1'b0;
    cyc("reset0", ST_NONE, 0, 0, 0, 0);
    cyc("reset1", ST_NONE, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("idle_no_run", ST_NONE, 0, 0, 0, 0);

    // Free-running short instructions: no idle gap
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("jmp_fetch", ST_FETCH, 1, 0, 0, i);
      cyc("jmp_exec1", ST_EXEC1, 1, 0, 0, i);
    end
    cyc("jmp_ret3", ST_FETCH, 1, 0, 0, 3);

    // MUL: four cycles, retires on the EXEC3 edge
    inst = OP_MUL;
    cyc("mul_exec1", ST_EXEC1, 1, 0, 0, 3);
    cyc("mul_exec2", ST_EXEC2, 1, 0, 0, 3);
    cyc("mul_exec3", ST_EXEC3, 1, 0, 0, 3);
    cyc("mul_done", ST_FETCH, 1, 0, 0, 4);

    // LDR with three wait cycles
    inst = OP_LDR; mem_ready = 1'b0;
    cyc("ldr_exec1", ST_EXEC1, 1, 0, 0, 4);
    cyc("ldr_exec2_in", ST_EXEC2, 1, 0, 0, 4);
    for (int i = 0; i < 3; i++) cyc("ldr_wait", ST_EXEC2, 1, 0, 0, 4);
    mem_ready = 1'b1;
    cyc("ldr_done", ST_FETCH, 1, 0, 0, 5);

    // LDA timeout: exactly 15 EXEC2 cycles then faulted halt
    inst = OP_LDA; mem_ready = 1'b0;
    cyc("lda_exec1", ST_EXEC1, 1, 0, 0, 5);
    for (int i = 0; i < 15; i++) cyc("lda_wait", ST_EXEC2, 1, 0, 0, 5);
    cyc("timeout_halt", ST_NONE, 0, 1, 1, 5);
    run = 1'b1; step_mode = 1'b1; step = 1'b1; mem_ready = 1'b1;
    cyc("halt_ignores_step", ST_NONE, 0, 1, 1, 5);
    step = 1'b0; step_mode = 1'b0;
    cyc("halt_ignores_run", ST_NONE, 0, 1, 1, 5);
    rst = 1'b1;
    cyc("halt_reset", ST_NONE, 0, 0, 0, 0);
    rst = 1'b0; run = 1'b0;

    // Single-step: IDLE between instructions, stray step in FETCH ignored
    step_mode = 1'b1; inst = 4'b0000;
    cyc("step_wait", ST_NONE, 0, 0, 0, 0);
    step = 1'b1;
    cyc("step1_fetch", ST_FETCH, 1, 0, 0, 0);
    step = 1'b1;
    cyc("step1_exec1", ST_EXEC1, 1, 0, 0, 0);
    step = 1'b0;
    cyc("step1_idle", ST_NONE, 0, 0, 0, 1);
    cyc("step_not_queued", ST_NONE, 0, 0, 0, 1);
    step = 1'b1;
    cyc("step2_fetch", ST_FETCH, 1, 0, 0, 1);
    step = 1'b0;
    cyc("step2_exec1", ST_EXEC1, 1, 0, 0, 1);
    cyc("step2_idle", ST_NONE, 0, 0, 0, 2);
    inst = OP_STP;
    step = 1'b1;
    cyc("step3_fetch", ST_FETCH, 1, 0, 0, 2);
    step = 1'b0;
    cyc("step3_exec1", ST_EXEC1, 1, 0, 0, 2);
    cyc("stp_halt", ST_NONE, 0, 1, 0, 2);
    rst = 1'b1;
    cyc("stp_reset", ST_NONE, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset held two cycles in EXEC2 of a MUL
    step_mode = 1'b0; run = 1'b1; inst = OP_MUL;
    cyc("t1_fetch", ST_FETCH, 1, 0, 0, 0);
    cyc("t1_exec1", ST_EXEC1, 1, 0, 0, 0);
    cyc("t1_exec2", ST_EXEC2, 1, 0, 0, 0);
    rst = 1'b1;
    cyc("t1_rst0", ST_NONE, 0, 0, 0, 0);
    cyc("t1_rst1", ST_NONE, 0, 0, 0, 0);
    rst = 1'b0; run = 1'b0;
    cyc("t1_idle", ST_NONE, 0, 0, 0, 0);

    // Counter wrap with a 4-bit retired counter
    run = 1'b1; inst = OP_JMP;
    for (int i = 0; i < 17; i++) begin
      cyc("wrap_fetch", ST_FETCH, 1, 0, 0, i);
      cyc("wrap_exec1", ST_EXEC1, 1, 0, 0, i);
    end
    cyc("wrap_fetch17", ST_FETCH, 1, 0, 0, 17);
    run = 1'b0;
    cyc("wrap_exec1_17", ST_EXEC1, 1, 0, 0, 17);
    cyc("stop_on_run_low", ST_NONE, 0, 0, 0, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
